// File: rtl/rv_pkg.sv
// rv_pkg: types and width defaults shared by the integer register-file
// writeback front end.
//   REG_WIDTH  - data width of one register
//   ADDR_WIDTH - register index width
//   reg_addr_t - register index
//   wb_entry_t - one queued load return (destination, data, kill flag)
package rv_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t              rd;
        logic [REG_WIDTH-1:0]   data;
        logic                   kill;   // superseded by a younger ALU write
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: handshake and write-port bundle of rf_writeback.
//   ALU completion : alu_valid / alu_ready / alu_rd / alu_data
//   Load return    : load_valid / load_ready / load_rd / load_data
//   Write port     : rd / write_data / reg_write
//   Hazard export  : pending_mask
// Modports: master = producer / consumer side, slave = rf_writeback.
interface rf_writeback_if #(
    parameter int REG_WIDTH  = rv_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH = rv_pkg::ADDR_WIDTH
);
    logic                         alu_valid;
    logic                         alu_ready;
    logic [ADDR_WIDTH-1:0]        alu_rd;
    logic [REG_WIDTH-1:0]         alu_data;
    logic                         load_valid;
    logic                         load_ready;
    logic [ADDR_WIDTH-1:0]        load_rd;
    logic [REG_WIDTH-1:0]         load_data;
    logic [ADDR_WIDTH-1:0]        rd;
    logic [REG_WIDTH-1:0]         write_data;
    logic                         reg_write;
    logic [(1<<ADDR_WIDTH)-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
        input  alu_ready, load_ready, rd, write_data, reg_write, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
        output alu_ready, load_ready, rd, write_data, reg_write, pending_mask
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry queue of load returns awaiting the write port.
//   clk, rst       - clock, synchronous active-high reset (empties queue)
//   push/push_entry, pop - enqueue / dequeue; ignored when full / empty
//   kill_set       - per-slot request to set the kill flag this cycle
//   full, empty    - from registered pointers carrying an extra wrap bit
//   head           - oldest entry
//   live, entry_rd, entry_kill - per-slot view for kill-marking and the mask
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic [DEPTH-1:0] kill_set,
    output logic             full,
    output logic             empty,
    output wb_entry_t        head,
    output logic [DEPTH-1:0] live,
    output reg_addr_t        entry_rd [DEPTH],
    output logic [DEPTH-1:0] entry_kill
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t   mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] count;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // A slot is live when its distance from the head is below the fill count.
    always_comb begin
        logic [PW-1:0] offs;
        offs = '0;
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs    = PW'(i) - rd_ptr[PW-1:0];
            live[i] = ({1'b0, offs} < count);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i]   = mem[i].rd;
            entry_kill[i] = mem[i].kill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].kill <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_set[i]) begin
                    mem[i].kill <= 1'b1;
                end
            end
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU results and queued load returns onto the single
// register-file write port, with x0 suppression, write-after-write kill of
// stale queued loads, and a starvation limit that forces a queue drain.
//   clk, rst - clock, synchronous active-high reset
//   bus      - rf_writeback_if.slave (ALU / load handshakes, write port,
//              pending_mask)
module rf_writeback
    import rv_pkg::*;
#(
    parameter int REG_WIDTH    = rv_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH   = rv_pkg::ADDR_WIDTH,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           rst,
    rf_writeback_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic             fifo_full;
    logic             fifo_empty;
    wb_entry_t        head;
    wb_entry_t        push_entry;
    logic [DEPTH-1:0] live;
    reg_addr_t        entry_rd [DEPTH];
    logic [DEPTH-1:0] entry_kill;
    logic [DEPTH-1:0] kill_set;
    logic             push;
    logic             pop;

    logic [CW-1:0]    starve_cnt;
    logic             force_drain;
    logic             alu_acc;
    logic             alu_emit;

    logic                  rw_d;
    logic [ADDR_WIDTH-1:0] rd_d;
    logic [REG_WIDTH-1:0]  data_d;
    logic [(1<<ADDR_WIDTH)-1:0] mask_c;

    // Handshakes depend on registered state only.
    assign force_drain    = !fifo_empty && (starve_cnt == CW'(STARVE_LIMIT));
    assign bus.alu_ready  = !force_drain;
    assign bus.load_ready = !fifo_full;

    assign alu_acc  = bus.alu_valid && !force_drain;
    assign alu_emit = alu_acc && (bus.alu_rd != '0);

    // Loads to x0 are accepted and dropped.
    assign push       = bus.load_valid && !fifo_full && (bus.load_rd != '0);
    assign push_entry = '{rd: bus.load_rd, data: bus.load_data, kill: 1'b0};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_set   (kill_set),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head),
        .live       (live),
        .entry_rd   (entry_rd),
        .entry_kill (entry_kill)
    );

    // Queued loads are older than the ALU result arriving now, so an ALU
    // write to the same register makes them dead. A load pushed this cycle
    // is not yet live and therefore never matches.
    always_comb begin
        kill_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_set[i] = alu_emit && live[i] && (entry_rd[i] == bus.alu_rd);
        end
    end

    always_comb begin
        pop    = 1'b0;
        rw_d   = 1'b0;
        rd_d   = '0;
        data_d = '0;
        if (force_drain) begin
            pop = 1'b1;
        end else if (alu_emit) begin
            rw_d   = 1'b1;
            rd_d   = bus.alu_rd;
            data_d = bus.alu_data;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
        // A killed head still leaves the queue but takes an empty write slot.
        if (pop && !head.kill) begin
            rw_d   = 1'b1;
            rd_d   = head.rd;
            data_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_write  <= 1'b0;
            bus.rd         <= '0;
            bus.write_data <= '0;
        end else begin
            bus.reg_write  <= rw_d;
            bus.rd         <= rd_d;
            bus.write_data <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        mask_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && !entry_kill[i]) begin
                mask_c[entry_rd[i]] = 1'b1;
            end
        end
    end

    assign bus.pending_mask = mask_c;
endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;
    import rv_pkg::*;

    localparam int DEP = 4;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_if #(.REG_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rf_writeback #(.REG_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEP), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } m_entry_t;

    m_entry_t    q[$];
    int          scnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) if (!q[i].kill) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive, check handshakes, advance model, check outputs.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit          fd, aacc, lacc, was_empty, popped, exp_rw;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wd;
        m_entry_t    e;
        bus.alu_valid  = av;
        bus.alu_rd     = ard;
        bus.alu_data   = ad;
        bus.load_valid = lv;
        bus.load_rd    = lrd;
        bus.load_data  = ld;
        fd = (scnt == LIM) && (q.size() > 0);
        chk("alu_ready", bus.alu_ready, !fd);
        chk("load_ready", bus.load_ready, q.size() < DEP);
        aacc      = av && !fd;
        lacc      = lv && (q.size() < DEP);
        was_empty = (q.size() == 0);
        popped    = 0;
        exp_rw    = 0;
        exp_rd    = '0;
        exp_wd    = '0;
        if (aacc && ard != 0) begin
            foreach (q[i]) if (q[i].rd == ard) q[i].kill = 1;
        end
        if (!fd && aacc && ard != 0) begin
            exp_rw = 1; exp_rd = ard; exp_wd = ad;
        end else if (!was_empty) begin
            e = q.pop_front();
            popped = 1;
            if (!e.kill) begin
                exp_rw = 1; exp_rd = e.rd; exp_wd = e.data;
            end
        end
        if (lacc && lrd != 0) q.push_back('{rd: lrd, data: ld, kill: 0});
        if (was_empty || popped) scnt = 0;
        else if (scnt < LIM) scnt++;
        @(posedge clk);
        #1;
        chk("reg_write", bus.reg_write, exp_rw);
        if (exp_rw) begin
            chk("rd", bus.rd, exp_rd);
            chk("write_data", bus.write_data, exp_wd);
        end
        chk("pending_mask", bus.pending_mask, model_mask());
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.alu_valid  = 0; bus.alu_rd  = 0; bus.alu_data  = 0;
        bus.load_valid = 0; bus.load_rd = 0; bus.load_data = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        scnt = 0;
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_pending_mask", bus.pending_mask, 0);
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_alu_ready", bus.alu_ready, 1);
    endtask

    initial begin
        int first_k;
        bit av, lv;
        scnt = 0;
        do_reset();
        idle();
        idle();

        // ALU only, then ALU to x0
        step(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(1, 0, 32'h12345678, 0, 0, 0);
        idle();

        // Fill the queue while the ALU holds the port
        for (int i = 1; i <= 4; i++) step(1, 10, 32'h1000 + i, 1, 5'(i), 32'hA000 + i);
        chk("fill_load_ready", bus.load_ready, 0);
        chk("fill_mask", bus.pending_mask, 32'h0000_001E);
        for (int i = 0; i < 5; i++) idle();

        // WAW kill
        step(0, 0, 0, 1, 7, 32'h11);
        chk("waw_mask_before", bus.pending_mask, 32'h80);
        step(1, 7, 32'h22, 0, 0, 0);
        chk("waw_mask_after", bus.pending_mask, 0);
        idle();
        idle();

        // Starvation: one load to x3 under continuous ALU traffic to x9
        step(1, 9, 32'h900, 1, 3, 32'h333);
        first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            if (!bus.alu_ready && first_k < 0) first_k = k;
            step(1, 9, 32'h900 + k, 0, 0, 0);
        end
        chk("starve_cycle", first_k, 9);
        idle();

        // Load to x0 is accepted and dropped
        step(0, 0, 0, 1, 0, 32'hFFFF);
        chk("x0_load_mask", bus.pending_mask, 0);
        idle();

        // Randomised traffic with frequent register collisions
        for (int n = 0; n < 600; n++) begin
            av = ($urandom_range(0, 9) < 7);
            lv = ($urandom_range(0, 9) < 5);
            step(av, 5'($urandom_range(0, 7)), $urandom(),
                 lv, 5'($urandom_range(0, 7)), $urandom());
        end
        for (int i = 0; i < 6; i++) idle();

        // Reset with three queued loads
        for (int i = 0; i < 3; i++) step(1, 20, 32'h2000 + i, 1, 5'(11 + i), 32'hB000 + i);
        chk("pre_rst_mask", bus.pending_mask, 32'h0000_3800);
        do_reset();
        for (int i = 0; i < 5; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writer-side front end for the integer register file.
- Merges two completion streams into the file's single write port (rd / write_data / reg_write):
  - the single-cycle ALU result path;
  - the multi-cycle load-return path, buffered in a small FIFO.
- Enforces x0 suppression, write-after-write ordering and anti-starvation.
- Exports a pending-load mask for the hazard unit.

Parameters:
- REG_WIDTH, 32, data width of one register
- ADDR_WIDTH, 5, register index width (1<<ADDR_WIDTH registers)
- DEPTH, 4, load-return FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive un-drained cycles before a forced drain

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  ADDR_WIDTH  ALU destination
- alu_data  input  REG_WIDTH  ALU result
- load_valid  input  1  load return offered
- load_ready  output  1  FIFO can accept
- load_rd  input  ADDR_WIDTH  load destination
- load_data  input  REG_WIDTH  load data
- rd  output  ADDR_WIDTH  register-file write address
- write_data  output  REG_WIDTH  register-file write data
- reg_write  output  1  register-file write enable
- pending_mask  output  1<<ADDR_WIDTH  bit r set = live queued load to r

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - rd, write_data, reg_write = 0.
  - FIFO empty, all kill bits clear.
  - Starvation counter = 0.
  - pending_mask = 0.
- Reset mid-operation discards all queued entries; no write is emitted for them.
- Outputs rd / write_data / reg_write are registered: a result selected in cycle N is written by the register file at the edge ending cycle N+1.
- load_ready = !full. Full and empty come from registered pointers with one extra wrap bit.
  - Load accepted when load_valid && load_ready.
  - load_rd==0: accepted but not enqueued.
- alu_ready = !force_drain.
  - force_drain is asserted when starve_cnt == STARVE_LIMIT and the FIFO is non-empty.
  - ALU accepted when alu_valid && alu_ready.
- Write-port selection each cycle, in priority order:
  1. force_drain → pop head.
  2. ALU accepted with alu_rd != 0 → emit ALU result.
  3. FIFO non-empty → pop head.
  4. Otherwise reg_write=0.
- ALU accepted with alu_rd==0 → nothing emitted; the FIFO may pop in the same cycle.
- Popped entry with kill=1 → reg_write=0 for that slot.
- Starvation counter:
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Program order equals arrival order at this block.
  - An accepted ALU write with alu_rd = r != 0 sets kill on every entry present at the start of that cycle whose rd == r.
  - A load accepted in the same cycle is younger and is not killed.
- pending_mask is the OR of one-hots for valid, non-killed entries, from registered state only.
- Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when full: not possible, because load_ready=0.
  - Simultaneous push and pop when non-full: count unchanged.
- load_ready and alu_ready are combinational from registered state only; no dependence on valid inputs.

Decomposition:
- Shared package rv_pkg holds:
  - REG_WIDTH and ADDR_WIDTH defaults;
  - typedef wb_entry_t {rd, data, kill};
  - typedef reg_addr_t.
- One natural sub-module: wb_fifo, a DEPTH-entry FIFO of wb_entry_t.
  - Exposes push, pop, full, empty and a per-entry view for kill-marking and the mask.
- Arbitration and the starvation counter live in rf_writeback.

Test Plan:
- Reset then idle:
  - Expect rd=0, write_data=0, reg_write=0, pending_mask=0, load_ready=1, alu_ready=1.
- ALU only:
  - Stimulus: alu_rd=5, alu_data=0xDEADBEEF for 1 cycle.
  - Expect next cycle reg_write=1, rd=5, write_data=0xDEADBEEF.
  - alu_rd=0 → reg_write stays 0.
- Load fill, DEPTH=4:
  - Stimulus: 4 loads to x1..x4 while ALU busy to x10.
  - Expect load_ready=0 after the 4th; pending_mask=0x1E.
  - After ALU stops, writes x1,x2,x3,x4 in order on consecutive cycles.
- WAW kill:
  - Stimulus: load x7=0x11 queued; then ALU x7=0x22.
  - Expect write x7=0x22; later pop of the load gives reg_write=0; pending_mask bit 7 clears at the kill.
- Starvation, STARVE_LIMIT=8:
  - Stimulus: continuous alu_valid to x9 with 1 queued load to x3.
  - Expect alu_ready=0 on cycle 9; x3 written; alu_ready=1 next cycle.
- Reset mid-operation:
  - Stimulus: rst with 3 queued loads.
  - Expect no further reg_write; pending_mask=0; load_ready=1.
